// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (IF) and data access (MEM).
// Registered grant FSM with per-requester ack pulses, fetch starvation guard and sticky timeout flag.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate eligible requesters
// GNT_IF  | fetch access outstanding on the memory port
// GNT_MEM | data access outstanding on the memory port
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_dmtype,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_dmtype,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]         NOP_INSN   = 32'h0000_0013;
    localparam logic [2:0]          DMTYPE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        GNT_IF,
        GNT_MEM
    } state_t;

    state_t              state_q, state_d;
    logic                m_req_q, m_req_d;
    logic                m_we_q, m_we_d;
    logic [31:0]         m_addr_q, m_addr_d;
    logic [31:0]         m_wdata_q, m_wdata_d;
    logic [2:0]          m_dmtype_q, m_dmtype_d;
    logic                if_ack_q, if_ack_d;
    logic                mem_ack_q, mem_ack_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;
    logic                err_q, err_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic if_elig;
    logic mem_elig;
    logic starved;

    // A request still held high during its own ack cycle must not be re-granted.
    assign if_elig  = if_req & ~if_ack_q;
    assign mem_elig = mem_req & ~mem_ack_q;
    assign starved  = (starve_q == STARVE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_dmtype_q  <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
            starve_q    <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_dmtype_q  <= m_dmtype_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_dmtype_d  = m_dmtype_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;
        starve_d    = starve_q;
        wait_d      = wait_q;

        case (state_q)
            IDLE: begin
                if (mem_elig && (!if_elig || !starved)) begin
                    state_d    = GNT_MEM;
                    m_req_d    = 1'b1;
                    m_we_d     = mem_we;
                    m_addr_d   = mem_addr;
                    m_wdata_d  = mem_wdata;
                    m_dmtype_d = mem_dmtype;
                    wait_d     = '0;
                    if (if_elig && !starved) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (if_elig) begin
                    state_d    = GNT_IF;
                    m_req_d    = 1'b1;
                    m_we_d     = 1'b0;
                    m_addr_d   = if_addr;
                    m_wdata_d  = '0;
                    m_dmtype_d = DMTYPE_WORD;
                    wait_d     = '0;
                    starve_d   = '0;
                end
            end
            GNT_IF, GNT_MEM: begin
                if (m_ready) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (state_q == GNT_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = m_rdata;
                    end else begin
                        mem_ack_d = 1'b1;
                        if (!m_we_q) begin
                            mem_rdata_d = m_rdata;
                        end
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Abort: hand the pipeline a harmless result so it can make progress.
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == GNT_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = NOP_INSN;
                    end else begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_dmtype  = m_dmtype_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign err       = err_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = mem_req & ~mem_ack_q;

endmodule
